// File: rtl/pc_stack.sv
// Program counter with a hardware call/return stack for the nRisk core.
// Holds the fetch address and updates it each clock. Supports stall, absolute
// jump, PC-relative branch, and call/return with sticky overflow/underflow flags.
module pc_stack #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 4,
   parameter int RESET_ADDR = 0,
   parameter int STEP       = 1
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic                       jump,
   input  logic                       branch,
   input  logic                       call,
   input  logic                       ret,
   input  logic [WIDTH-1:0]           target,
   input  logic [WIDTH-1:0]           offset,
   output logic [WIDTH-1:0]           pc,
   output logic [WIDTH-1:0]           stack_top,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int DW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [WIDTH-1:0] stack_d [DEPTH];
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic [WIDTH-1:0] pcInc;
   logic [WIDTH-1:0] topVal;
   logic [DW-1:0]    topIdx;

   // Select the return address at the top of the stack; reads as 0 when empty.
   always_comb begin
      topIdx = depth_q - DW'(1);
      topVal = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((depth_q != '0) && (DW'(i) == topIdx)) begin
            topVal = stack_q[i];
         end
      end
   end

   // Next-state logic: one command acts per enabled cycle, ret > call > jump > branch > sequential.
   always_comb begin
      pcInc       = pc_q + WIDTH'(STEP);
      pc_d        = pc_q;
      depth_d     = depth_q;
      stack_d     = stack_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (enable) begin
         if (ret) begin
            if (depth_q != '0) begin
               pc_d    = topVal;
               depth_d = depth_q - DW'(1);
               for (int i = 0; i < DEPTH; i++) begin
                  if (DW'(i) == topIdx) begin
                     stack_d[i] = '0;
                  end
               end
            end else begin
               underflow_d = 1'b1;
               pc_d        = pcInc;
            end
         end else if (call) begin
            if (depth_q != DW'(DEPTH)) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (DW'(i) == depth_q) begin
                     stack_d[i] = pcInc;
                  end
               end
               depth_d = depth_q + DW'(1);
               pc_d    = target;
            end else begin
               overflow_d = 1'b1;
               pc_d       = pcInc;
            end
         end else if (jump) begin
            pc_d = target;
         end else if (branch) begin
            pc_d = pc_q + offset;
         end else begin
            pc_d = pcInc;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q        <= WIDTH'(RESET_ADDR);
         depth_q     <= '0;
         stack_q     <= '{default: '0};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         depth_q     <= depth_d;
         stack_q     <= stack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign pc        = pc_q;
   assign stack_top = topVal;
   assign depth     = depth_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed testbench for pc_stack with WIDTH=8, DEPTH=4, RESET_ADDR=0, STEP=1.
module tb_pc_stack;

   logic       clock;
   logic       reset_n;
   logic       enable;
   logic       jump;
   logic       branch;
   logic       call;
   logic       ret;
   logic [7:0] target;
   logic [7:0] offset;
   logic [7:0] pc;
   logic [7:0] stack_top;
   logic [2:0] depth;
   logic       overflow;
   logic       underflow;

   int testsRun    = 0;
   int testsFailed = 0;

   pc_stack #(.WIDTH(8), .DEPTH(4), .RESET_ADDR(0), .STEP(1)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .enable    (enable),
      .jump      (jump),
      .branch    (branch),
      .call      (call),
      .ret       (ret),
      .target    (target),
      .offset    (offset),
      .pc        (pc),
      .stack_top (stack_top),
      .depth     (depth),
      .overflow  (overflow),
      .underflow (underflow)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to 1ns past the next rising edge, where outputs are sampled and inputs changed.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic r, input logic c, input logic j,
                                input logic b, input logic [7:0] tgt, input logic [7:0] off);
      enable = en; ret = r; call = c; jump = j; branch = b; target = tgt; offset = off;
   endtask

   // Pulse reset away from any clock edge and leave the command inputs idle.
   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      #12;
      testsRun++;
      if (pc !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_pc: got %h want 00", pc); end
      testsRun++;
      if (depth !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_depth: got %0d want 0", depth); end
      testsRun++;
      if ({overflow, underflow, stack_top} !== 10'h000) begin
         testsFailed++; $display("[TB] FAIL reset_flags_top: ovf=%b unf=%b top=%h want 0 0 00", overflow, underflow, stack_top);
      end
      reset_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         testsRun++;
         if (pc !== 8'(i)) begin testsFailed++; $display("[TB] FAIL seq_step%0d: got %h want %h", i, pc, 8'(i)); end
      end
   endtask

   task automatic test_async_reset();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      testsRun++;
      if (pc !== 8'h00) begin testsFailed++; $display("[TB] FAIL async_reset_pc: got %h want 00", pc); end
      reset_n = 1'b1;
   endtask

   task automatic test_stall();
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h00);
      for (int i = 0; i < 2; i++) begin
         tick();
         testsRun++;
         if (pc !== 8'h10) begin testsFailed++; $display("[TB] FAIL stall_hold%0d: got %h want 10", i, pc); end
      end
      enable = 1'b1;
      tick();
      testsRun++;
      if (pc !== 8'h80) begin testsFailed++; $display("[TB] FAIL stall_release: got %h want 80", pc); end
   endtask

   task automatic test_branch();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hF0);
      tick();
      testsRun++;
      if (pc !== 8'h00) begin testsFailed++; $display("[TB] FAIL branch_back: got %h want 00", pc); end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFE, 8'h00);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h05);
      tick();
      testsRun++;
      if (pc !== 8'h03) begin testsFailed++; $display("[TB] FAIL branch_wrap: got %h want 03", pc); end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      testsRun++;
      if (pc !== 8'h00) begin testsFailed++; $display("[TB] FAIL seq_wrap: got %h want 00", pc); end
   endtask

   task automatic test_calls();
      logic [7:0] tgts  [4] = '{8'h40, 8'h60, 8'h80, 8'hA0};
      logic [7:0] tops  [4] = '{8'h21, 8'h41, 8'h61, 8'h81};
      logic [7:0] retPc [4] = '{8'h81, 8'h61, 8'h41, 8'h21};
      logic [7:0] retTop[4] = '{8'h61, 8'h41, 8'h21, 8'h00};
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
      tick();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, tgts[i], 8'h00);
         tick();
         testsRun++;
         if ({pc, stack_top, depth} !== {tgts[i], tops[i], 3'(i + 1)}) begin
            testsFailed++;
            $display("[TB] FAIL call%0d: pc=%h top=%h depth=%0d want %h %h %0d", i, pc, stack_top, depth, tgts[i], tops[i], i + 1);
         end
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC0, 8'h00);
      tick();
      testsRun++;
      if ({overflow, underflow, pc, depth, stack_top} !== {1'b1, 1'b0, 8'hA1, 3'd4, 8'h81}) begin
         testsFailed++;
         $display("[TB] FAIL call_overflow: ovf=%b unf=%b pc=%h depth=%0d top=%h want 1 0 a1 4 81", overflow, underflow, pc, depth, stack_top);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         tick();
         testsRun++;
         if ({pc, stack_top, depth} !== {retPc[i], retTop[i], 3'(3 - i)}) begin
            testsFailed++;
            $display("[TB] FAIL ret%0d: pc=%h top=%h depth=%0d want %h %h %0d", i, pc, stack_top, depth, retPc[i], retTop[i], 3 - i);
         end
      end
      tick();
      testsRun++;
      if ({underflow, overflow, pc, depth} !== {1'b1, 1'b1, 8'h22, 3'd0}) begin
         testsFailed++;
         $display("[TB] FAIL ret_underflow: unf=%b ovf=%b pc=%h depth=%0d want 1 1 22 0", underflow, overflow, pc, depth);
      end
   endtask

   task automatic test_priority();
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h32, 8'h00);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h50, 8'h00);
      tick();
      testsRun++;
      if ({pc, stack_top, depth} !== {8'h50, 8'h33, 3'd1}) begin
         testsFailed++; $display("[TB] FAIL prio_setup: pc=%h top=%h depth=%0d want 50 33 1", pc, stack_top, depth);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h99, 8'h07);
      tick();
      testsRun++;
      if ({pc, stack_top, depth} !== {8'h50, 8'h33, 3'd1}) begin
         testsFailed++; $display("[TB] FAIL stall_stack_hold: pc=%h top=%h depth=%0d want 50 33 1", pc, stack_top, depth);
      end
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h99, 8'h00);
      tick();
      testsRun++;
      if ({pc, stack_top, depth, underflow, overflow} !== {8'h33, 8'h00, 3'd0, 1'b0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL prio_ret_wins: pc=%h top=%h depth=%0d unf=%b ovf=%b want 33 00 0 0 0", pc, stack_top, depth, underflow, overflow);
      end
   endtask

   task automatic test_call_wrap();
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
      tick();
      testsRun++;
      if ({pc, stack_top, depth} !== {8'h10, 8'h00, 3'd1}) begin
         testsFailed++; $display("[TB] FAIL call_wrap: pc=%h top=%h depth=%0d want 10 00 1", pc, stack_top, depth);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      testsRun++;
      if ({pc, depth, underflow} !== {8'h00, 3'd0, 1'b0}) begin
         testsFailed++; $display("[TB] FAIL ret_wrap: pc=%h depth=%0d unf=%b want 00 0 0", pc, depth, underflow);
      end
   endtask

   // Run each scenario in turn, then report.
   initial begin
      test_reset();
      test_async_reset();
      test_stall();
      test_branch();
      test_calls();
      test_priority();
      test_call_wrap();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
